// File: rtl/conv_out_buf_writer_if.sv
// Beat stream from the conv store controller plus the output-buffer write port.
// master = beat source / buffer sink, slave = the buffer writer.
interface conv_out_buf_writer_if #(
  parameter int OUT_DATA_WIDTH = 256,
  parameter int BUF_ADR_WIDTH  = 16
);
  logic                        in_valid;
  logic [15:0]                 in_y_idx;
  logic [15:0]                 in_x_idx;
  logic [15:0]                 in_f_idx;
  logic [OUT_DATA_WIDTH-1:0]   in_data;
  logic                        in_tile_end;

  logic                        buf_wr_en;
  logic [BUF_ADR_WIDTH-1:0]    buf_wr_adr;
  logic [2*OUT_DATA_WIDTH-1:0] buf_wr_data;
  logic [1:0]                  buf_wr_mask;

  modport master (
    output in_valid, in_y_idx, in_x_idx, in_f_idx, in_data, in_tile_end,
    input  buf_wr_en, buf_wr_adr, buf_wr_data, buf_wr_mask
  );

  modport slave (
    input  in_valid, in_y_idx, in_x_idx, in_f_idx, in_data, in_tile_end,
    output buf_wr_en, buf_wr_adr, buf_wr_data, buf_wr_mask
  );
endinterface

// File: rtl/conv_out_buf_writer.sv
// Conv output buffer writer: maps channel-row beats to buffer word addresses,
// pairs adjacent rows into double-width words and flushes a lone half at tile end.
// No backpressure; at most one registered write per cycle.
module conv_out_buf_writer #(
  parameter int PIXELS_IN_ROW         = 32,
  parameter int PIXELS_IN_ROW_IN_2POW = 5,
  parameter int OUT_DATA_WIDTH        = 256,
  parameter int BUF_ADR_WIDTH         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  conv_out_buf_writer_if.slave   io_bus,
  input  logic [3:0]             i_of_in_2pow,
  input  logic [3:0]             i_ox_in_2pow,
  output logic                   o_tile_done,
  output logic [15:0]            o_wr_count,
  output logic                   o_seq_err
);
  localparam int DW = OUT_DATA_WIDTH;
  localparam int AW = BUF_ADR_WIDTH;

  // pending half-word
  logic          r_pend_vld, r_pend_lane, r_pend_last, r_flush_req;
  logic [AW-1:0] r_pend_adr;
  logic [DW-1:0] r_pend_data;

  // registered write port
  logic            r_wr_en, r_tile_done, r_seq_err;
  logic [AW-1:0]   r_wr_adr;
  logic [2*DW-1:0] r_wr_data;
  logic [1:0]      r_wr_mask;
  logic [15:0]     r_wr_count;

  // next-state / write decision
  logic            w_nxt_vld, w_nxt_lane, w_nxt_last, w_nxt_flush;
  logic [AW-1:0]   w_nxt_adr;
  logic [DW-1:0]   w_nxt_data;
  logic            w_wr_en, w_done, w_err;
  logic [AW-1:0]   w_wr_adr;
  logic [2*DW-1:0] w_wr_data;
  logic [1:0]      w_wr_mask;

  // beat address: y term is shifted left by (of+ox-log2 pixels), the x term
  // scales by channel extent and divides by the row segment length
  logic [4:0]      w_sh_y;
  logic [31:0]     w_lin;
  logic [AW-1:0]   w_adr;
  logic            w_lane;
  logic            w_unused_lin;
  logic            w_same_adr;
  logic [2*DW-1:0] w_new_word, w_pend_word;
  logic [1:0]      w_pend_mask;

  assign w_sh_y = ({1'b0, i_of_in_2pow} + {1'b0, i_ox_in_2pow}) - 5'(PIXELS_IN_ROW_IN_2POW);
  assign w_lin  = (32'(io_bus.in_y_idx) << w_sh_y)
                + ((32'(io_bus.in_x_idx) << i_of_in_2pow) / 32'(PIXELS_IN_ROW))
                + 32'(io_bus.in_f_idx);
  assign w_adr        = w_lin[AW:1];
  assign w_lane       = w_lin[0];
  assign w_unused_lin = ^w_lin[31:AW+1];

  assign w_same_adr  = r_pend_vld && (w_adr == r_pend_adr);
  assign w_new_word  = w_lane      ? {io_bus.in_data, {DW{1'b0}}} : {{DW{1'b0}}, io_bus.in_data};
  assign w_pend_word = r_pend_lane ? {r_pend_data,    {DW{1'b0}}} : {{DW{1'b0}}, r_pend_data};
  assign w_pend_mask = r_pend_lane ? 2'b10 : 2'b01;

  // pick the first matching pairing rule and compute the write and next pending state
  always_comb begin
    w_nxt_vld   = r_pend_vld;
    w_nxt_adr   = r_pend_adr;
    w_nxt_lane  = r_pend_lane;
    w_nxt_data  = r_pend_data;
    w_nxt_last  = r_pend_last;
    w_nxt_flush = r_flush_req;
    w_wr_en     = 1'b0;
    w_wr_adr    = '0;
    w_wr_data   = '0;
    w_wr_mask   = 2'b00;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (io_bus.in_valid) begin
      if (w_same_adr && (w_lane != r_pend_lane)) begin
        // partner row arrived: one full word, nothing left to flush
        w_wr_en     = 1'b1;
        w_wr_adr    = r_pend_adr;
        w_wr_data   = w_pend_word | w_new_word;
        w_wr_mask   = 2'b11;
        w_done      = io_bus.in_tile_end | r_pend_last;
        w_nxt_vld   = 1'b0;
        w_nxt_flush = 1'b0;
      end else begin
        if (r_pend_vld) begin
          // old half can no longer be paired; write it alone
          w_wr_en   = 1'b1;
          w_wr_adr  = r_pend_adr;
          w_wr_data = w_pend_word;
          w_wr_mask = w_pend_mask;
          w_done    = r_pend_last;
          w_err     = w_same_adr;
        end
        w_nxt_vld   = 1'b1;
        w_nxt_adr   = w_adr;
        w_nxt_lane  = w_lane;
        w_nxt_data  = io_bus.in_data;
        w_nxt_last  = io_bus.in_tile_end;
        w_nxt_flush = io_bus.in_tile_end;
      end
    end else if (r_flush_req && r_pend_vld) begin
      w_wr_en     = 1'b1;
      w_wr_adr    = r_pend_adr;
      w_wr_data   = w_pend_word;
      w_wr_mask   = w_pend_mask;
      w_done      = 1'b1;
      w_nxt_vld   = 1'b0;
      w_nxt_flush = 1'b0;
    end
  end

  // pending half-word register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld  <= 1'b0;
      r_pend_adr  <= '0;
      r_pend_lane <= 1'b0;
      r_pend_data <= '0;
      r_pend_last <= 1'b0;
      r_flush_req <= 1'b0;
    end else begin
      r_pend_vld  <= w_nxt_vld;
      r_pend_adr  <= w_nxt_adr;
      r_pend_lane <= w_nxt_lane;
      r_pend_data <= w_nxt_data;
      r_pend_last <= w_nxt_last;
      r_flush_req <= w_nxt_flush;
    end
  end

  // registered write port, write counter and sticky protocol error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en     <= 1'b0;
      r_wr_adr    <= '0;
      r_wr_data   <= '0;
      r_wr_mask   <= 2'b00;
      r_tile_done <= 1'b0;
      r_wr_count  <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_en;
      r_wr_adr    <= w_wr_adr;
      r_wr_data   <= w_wr_data;
      r_wr_mask   <= w_wr_mask;
      r_tile_done <= w_done;
      r_wr_count  <= r_wr_count + 16'(w_wr_en);
      r_seq_err   <= r_seq_err | w_err;
    end
  end

  assign io_bus.buf_wr_en   = r_wr_en;
  assign io_bus.buf_wr_adr  = r_wr_adr;
  assign io_bus.buf_wr_data = r_wr_data;
  assign io_bus.buf_wr_mask = r_wr_mask;
  assign o_tile_done        = r_tile_done;
  assign o_wr_count         = r_wr_count;
  assign o_seq_err          = r_seq_err;
endmodule

// File: tb/tb_conv_out_buf_writer.sv
// Bench for conv_out_buf_writer: reset checks, hand-written pairing/flush
// sequences, a table of single-beat address vectors and randomized tiles
// checked against a list-based reference model.
module tb_conv_out_buf_writer;
  localparam int W = 256;
  localparam int A = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cfg_of = 4'd5;
  logic [3:0]  cfg_ox = 4'd2;
  logic        tile_done;
  logic [15:0] wr_count;
  logic        seq_err;

  conv_out_buf_writer_if #(.OUT_DATA_WIDTH(W), .BUF_ADR_WIDTH(A)) bus ();

  conv_out_buf_writer #(
    .PIXELS_IN_ROW(32), .PIXELS_IN_ROW_IN_2POW(5),
    .OUT_DATA_WIDTH(W), .BUF_ADR_WIDTH(A)
  ) dut (
    .clk(clk), .reset(reset), .io_bus(bus),
    .i_of_in_2pow(cfg_of), .i_ox_in_2pow(cfg_ox),
    .o_tile_done(tile_done), .o_wr_count(wr_count), .o_seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]    adr;
    logic [1:0]     mask;
    logic [2*W-1:0] data;
    logic           done;
  } wr_t;

  typedef struct {
    logic [3:0]  of4;
    logic [3:0]  ox4;
    logic [15:0] y;
    logic [15:0] x;
    logic [15:0] f;
    logic [15:0] exp_adr;
    logic [1:0]  exp_mask;
  } vec_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  exp_err;
  int  n_wr;

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [2*W-1:0] place(input logic [W-1:0] d, input logic lane);
    logic [2*W-1:0] r;
    r = '0;
    if (lane) r[2*W-1:W] = d; else r[W-1:0] = d;
    return r;
  endfunction

  // reference: {adr, lane} = linear index bits [16:0]
  function automatic logic [16:0] ref_map(input int of, input int ox, input int y, input int x, input int f);
    longint l;
    l = longint'(y) * (longint'(1) << (of + ox - 5)) + (longint'(x) * (longint'(1) << of)) / 32 + longint'(f);
    return l[16:0];
  endfunction

  task automatic push(input logic [15:0] adr, input logic [1:0] mask, input logic [2*W-1:0] data, input logic done);
    wr_t e;
    e.adr = adr; e.mask = mask; e.data = data; e.done = done;
    exp_q.push_back(e);
    n_wr++;
  endtask

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic beat(input int y, input int x, input int f, input logic [W-1:0] d, input logic te);
    bus.in_valid    = 1'b1;
    bus.in_y_idx    = 16'(y);
    bus.in_x_idx    = 16'(x);
    bus.in_f_idx    = 16'(f);
    bus.in_data     = d;
    bus.in_tile_end = te;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_tile_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    check("expected_writes_drained", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    idle(1);
    n_wr = 0;
  endtask

  // write monitor: every write must match the next expected one
  always @(negedge clk) begin
    if (reset) begin
      if (bus.buf_wr_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: adr=%h mask=%b done=%b", bus.buf_wr_adr, bus.buf_wr_mask, tile_done);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (bus.buf_wr_adr !== e.adr || bus.buf_wr_mask !== e.mask ||
              bus.buf_wr_data !== e.data || tile_done !== e.done) begin
            n_err++;
            $display("FAIL write: got adr=%h mask=%b done=%b data=%h want adr=%h mask=%b done=%b data=%h",
                     bus.buf_wr_adr, bus.buf_wr_mask, tile_done, bus.buf_wr_data,
                     e.adr, e.mask, e.done, e.data);
          end
        end
      end else if (tile_done) begin
        n_cmp++;
        n_err++;
        $display("FAIL tile_done_without_write: got 1, want 0");
      end
    end
  end

  vec_t vecs[8];
  logic [W-1:0] d[16];

  initial begin
    bus.in_valid = 1'b0; bus.in_y_idx = '0; bus.in_x_idx = '0;
    bus.in_f_idx = '0;   bus.in_data = '0;  bus.in_tile_end = 1'b0;
    n_wr = 0;

    vecs[0] = '{4'd5, 4'd2, 16'd0,      16'd0,  16'd5,      16'd2,      2'b10};
    vecs[1] = '{4'd5, 4'd2, 16'd1,      16'd0,  16'd0,      16'd2,      2'b01};
    vecs[2] = '{4'd4, 4'd3, 16'd2,      16'd40, 16'd3,      16'd15,     2'b10};
    vecs[3] = '{4'd6, 4'd4, 16'd3,      16'd7,  16'd9,      16'd59,     2'b10};
    vecs[4] = '{4'd8, 4'd8, 16'h1234,   16'd0,  16'd0,      16'hD000,   2'b01};
    vecs[5] = '{4'd5, 4'd0, 16'd3,      16'd0,  16'd10,     16'd6,      2'b10};
    vecs[6] = '{4'd0, 4'd5, 16'd1,      16'd33, 16'd0,      16'd1,      2'b01};
    vecs[7] = '{4'd15,4'd15,16'd1,      16'd1,  16'hFFFF,   16'h81FF,   2'b10};

    for (int i = 0; i < 16; i++) d[i] = rnd256();

    // reset state
    #2;
    check("reset_outputs", {bus.buf_wr_en, bus.buf_wr_mask, tile_done, seq_err, (|bus.buf_wr_adr), (|bus.buf_wr_data)}, 0);
    check("reset_wr_count", wr_count, 0);
    #5; reset = 1'b1;
    @(posedge clk); #1;

    // pair f=0/f=1 into one full word, written 1 cycle after the second beat
    push(16'd0, 2'b11, {d[1], d[0]}, 1'b0);
    beat(0, 0, 0, d[0], 1'b0);
    check("t1_no_write_after_first", bus.buf_wr_en, 0);
    beat(0, 0, 1, d[1], 1'b0);
    check("t1_write_latency", {bus.buf_wr_en, bus.buf_wr_mask}, 3'b111);
    idle(2);

    // 16 back-to-back rows -> 8 full words
    do_reset();
    for (int k = 0; k < 8; k++) push(16'(k), 2'b11, {d[2*k+1], d[2*k]}, k == 7);
    for (int f = 0; f < 16; f++) beat(0, 0, f, d[f], f == 15);
    idle(3);
    check("t2_wr_count", wr_count, 8);

    // odd row count: full word then flush of the lone half
    do_reset();
    push(16'd0, 2'b11, {d[1], d[0]}, 1'b0);
    push(16'd1, 2'b01, place(d[2], 1'b0), 1'b1);
    beat(0, 0, 0, d[0], 1'b0);
    beat(0, 0, 1, d[1], 1'b0);
    beat(0, 0, 2, d[2], 1'b1);
    idle(1);
    check("t3_flush_first_idle", {bus.buf_wr_en, bus.buf_wr_mask, tile_done}, 4'b1011);
    idle(2);

    // different address forces a partial write, tile-end beat flushes later
    do_reset();
    push(16'd1, 2'b10, place(d[3], 1'b1), 1'b0);
    push(16'd3, 2'b01, place(d[6], 1'b0), 1'b1);
    beat(0, 0, 3, d[3], 1'b0);
    beat(0, 0, 6, d[6], 1'b1);
    idle(4);
    check("t4_wr_count", wr_count, 2);

    // same address and lane twice -> sticky seq_err
    do_reset();
    push(16'd2, 2'b01, place(d[4], 1'b0), 1'b0);
    beat(0, 0, 4, d[4], 1'b0);
    check("t5_seq_err_before", seq_err, 0);
    beat(0, 0, 4, d[5], 1'b0);
    check("t5_seq_err_set", seq_err, 1);
    idle(5);
    check("t5_seq_err_sticky", seq_err, 1);

    // async reset with a flush pending: outputs clear at once, no write afterwards
    do_reset();
    check("t6_seq_err_cleared", seq_err, 0);
    push(16'd0, 2'b11, {d[1], d[0]}, 1'b0);
    beat(0, 0, 0, d[0], 1'b0);
    beat(0, 0, 1, d[1], 1'b0);
    beat(0, 0, 2, d[2], 1'b1);
    check("t6_count_before_reset", wr_count, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_clear", {bus.buf_wr_en, tile_done, seq_err, (|wr_count), (|bus.buf_wr_data)}, 0);
    #3 reset = 1'b1;
    idle(5);
    check("t6_no_write_after_release", wr_count, 0);

    // address table: single tile-end beat, flushed on the next idle cycle
    do_reset();
    foreach (vecs[i]) begin
      logic [W-1:0] v;
      v = rnd256();
      cfg_of = vecs[i].of4;
      cfg_ox = vecs[i].ox4;
      push(vecs[i].exp_adr, vecs[i].exp_mask, place(v, vecs[i].exp_mask[1]), 1'b1);
      beat(int'(vecs[i].y), int'(vecs[i].x), int'(vecs[i].f), v, 1'b1);
      idle(2);
    end
    check("table_wr_count", wr_count, 8);

    // randomized tiles against the reference model
    do_reset();
    exp_err = 1'b0;
    for (int t = 0; t < 60; t++) begin
      int of, ox, n, y, x, f;
      int ys[12], xs[12], fs[12];
      logic [W-1:0] ds[12];
      bit hv, hl, hlast;
      logic [15:0] ha;
      logic [W-1:0] hd;
      of = $urandom_range(3, 6);
      ox = $urandom_range(2, 5);
      n  = $urandom_range(1, 12);
      y  = $urandom_range(0, 3);
      x  = $urandom_range(0, 63);
      f  = $urandom_range(0, 31);
      for (int i = 0; i < n; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (i > 0) begin
          if (r < 2) f = $urandom_range(0, 31);
          else if (r != 2) f = f + 1;
          if (r == 9) x = $urandom_range(0, 63);
        end
        ys[i] = y; xs[i] = x; fs[i] = f; ds[i] = rnd256();
      end
      hv = 0; hl = 0; hlast = 0; ha = '0; hd = '0;
      for (int i = 0; i < n; i++) begin
        logic [16:0] m;
        bit last;
        m = ref_map(of, ox, ys[i], xs[i], fs[i]);
        last = (i == n - 1);
        if (hv && ha == m[16:1] && hl != m[0]) begin
          push(ha, 2'b11, place(hd, hl) | place(ds[i], m[0]), last | hlast);
          hv = 0;
        end else begin
          if (hv) begin
            if (ha == m[16:1]) exp_err = 1'b1;
            push(ha, hl ? 2'b10 : 2'b01, place(hd, hl), hlast);
          end
          hv = 1; ha = m[16:1]; hl = m[0]; hd = ds[i]; hlast = last;
        end
      end
      if (hv) push(ha, hl ? 2'b10 : 2'b01, place(hd, hl), 1'b1);
      cfg_of = 4'(of);
      cfg_ox = 4'(ox);
      for (int i = 0; i < n; i++) beat(ys[i], xs[i], fs[i], ds[i], i == n - 1);
      idle(2);
    end
    idle(2);
    check("rand_wr_count", wr_count, n_wr & 16'hFFFF);
    check("rand_seq_err", seq_err, exp_err);
    check("rand_writes_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
